// File: rtl/ad9516_spi_reader_if.sv
// Request/response and SPI pin bundle for the AD9516 read-back engine.
// master: the requester together with the device side (drives start/addr/SDO).
// slave : the read engine itself.
interface ad9516_spi_reader_if;
   logic        start;
   logic [12:0] reg_addr;
   logic        busy;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        spi_cs_n;
   logic        spi_sclk;
   logic        spi_sdio;
   logic        spi_sdo;

   modport master (
      output start, reg_addr, spi_sdo,
      input  busy, rd_data, rd_valid, spi_cs_n, spi_sclk, spi_sdio
   );

   modport slave (
      input  start, reg_addr, spi_sdo,
      output busy, rd_data, rd_valid, spi_cs_n, spi_sclk, spi_sdio
   );
endinterface

// File: rtl/ad9516_spi_reader.sv
// AD9516 single-byte SPI read engine.
// Shifts out {R/W=1, W1:W0=00, addr[12:0]} MSB first, then clocks in one
// register byte on SDO and reports it with a one-cycle rd_valid pulse.
// SCLK is generated from the system clock: CLK_DIV cycles per half period.
module ad9516_spi_reader #(
   parameter int unsigned CLK_DIV  = 4,   // system clocks per SCLK half period (2..255)
   parameter int unsigned HOLD_CYC = 4    // CS-high guard cycles after a transaction (1..255)
) (
   input  logic                clock,
   input  logic                reset_n,
   ad9516_spi_reader_if.slave  bus
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_INSTR = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
   localparam logic [3:0] INSTR_LAST = 4'd15;   // 16 instruction bits
   localparam logic [3:0] DATA_LAST  = 4'd7;    // 8 data bits

   logic [2:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;         // cycles spent in current phase
   logic [3:0]  bit_q, bit_d;         // completed SCLK periods in current state
   logic [15:0] tx_q, tx_d;           // instruction shift register
   logic [7:0]  rx_q, rx_d;           // read data shift register
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        busy_q, busy_d;
   logic        cs_n_q, cs_n_d;
   logic        sclk_q, sclk_d;
   logic        sdio_q, sdio_d;

   logic        phase_end;

   assign phase_end = (cnt_q == DIV_LAST);

   // Next-state logic: sequencing, SCLK generation, shift/capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      busy_d     = busy_q;
      cs_n_d     = cs_n_q;
      sclk_d     = sclk_q;
      sdio_d     = sdio_q;

      case (state_q)
         ST_IDLE: begin
            // start is only looked at here; everywhere else it is ignored.
            if (bus.start) begin
               tx_d    = {1'b1, 2'b00, bus.reg_addr};
               sdio_d  = 1'b1;           // instruction bit 15 (R/W=1)
               cs_n_d  = 1'b0;
               sclk_d  = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_SETUP;
            end
         end

         ST_SETUP: begin
            // Bit 15 is already on SDIO; give it a full half period of setup.
            if (phase_end) begin
               cnt_d   = '0;
               state_d = ST_INSTR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_INSTR: begin
            if (phase_end) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;         // device samples SDIO on this rise
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == INSTR_LAST) begin
                     sdio_d  = 1'b0;
                     bit_d   = '0;
                     state_d = ST_DATA;
                  end else begin
                     // SDIO only moves on the falling edge: present next bit.
                     bit_d  = bit_q + 4'd1;
                     tx_d   = {tx_q[14:0], 1'b0};
                     sdio_d = tx_q[14];
                  end
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_DATA: begin
            if (phase_end) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  // SDO was launched by our previous fall, so it is stable
                  // through the low phase; take it as we drive the rise.
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[6:0], bus.spi_sdo};
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == DATA_LAST) begin
                     cs_n_d     = 1'b1;
                     rd_data_d  = rx_q;
                     rd_valid_d = 1'b1;
                     bit_d      = '0;
                     state_d    = ST_HOLD;
                  end else begin
                     bit_d = bit_q + 4'd1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_HOLD: begin
            // CS stays high for the guard time while busy still reports 1.
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            busy_d  = 1'b0;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            sdio_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset forces CS high at once, even mid-transfer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         sclk_q     <= 1'b0;
         sdio_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
         cs_n_q     <= cs_n_d;
         sclk_q     <= sclk_d;
         sdio_q     <= sdio_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.spi_cs_n = cs_n_q;
   assign bus.spi_sclk = sclk_q;
   assign bus.spi_sdio = sdio_q;

endmodule

// File: tb/tb_ad9516_spi_reader.sv
// Bench for ad9516_spi_reader: two instances (defaults, and CLK_DIV=2/HOLD_CYC=1),
// an AD9516 SDO/SDIO model, and a scoreboard monitor on the falling clock edge.
module tb_ad9516_spi_reader;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [1:0]  rst_r   = 2'b00;
   logic [1:0]  start_r = 2'b00;
   logic [12:0] addr_r [2];
   logic [1:0]  sdo_r;

   logic [1:0]  busy_w, vld_w, cs_w, sclk_w, sdio_w;
   logic [7:0]  rdd_w [2];

   for (genvar g = 0; g < 2; g++) begin : g_u
      localparam int unsigned CD = (g == 0) ? 4 : 2;
      localparam int unsigned HC = (g == 0) ? 4 : 1;
      ad9516_spi_reader_if bus ();
      assign bus.start    = start_r[g];
      assign bus.reg_addr = addr_r[g];
      assign bus.spi_sdo  = sdo_r[g];
      assign busy_w[g]    = bus.busy;
      assign vld_w[g]     = bus.rd_valid;
      assign cs_w[g]      = bus.spi_cs_n;
      assign sclk_w[g]    = bus.spi_sclk;
      assign sdio_w[g]    = bus.spi_sdio;
      assign rdd_w[g]     = bus.rd_data;
      ad9516_spi_reader #(.CLK_DIV(CD), .HOLD_CYC(HC)) u_dut (
         .clock   (clock),
         .reset_n (rst_r[g]),
         .bus     (bus.slave)
      );
   end

   typedef struct {
      logic [12:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t       exp_q0[$], exp_q1[$];
   logic [7:0] dev_q0[$], dev_q1[$];

   int nchk = 0, npass = 0, nto = 0;
   logic [1:0] chk_b2b = 2'b00;
   bit fin_req = 1'b0, fin_done = 1'b0;

   // monitor-owned state
   int          cyc = 0;
   bit   [1:0]  rst_done, prev_cs, prev_sclk, have_last;
   int          rises [2], busy_len [2], last_fall [2], high_run [2], viol [2];
   logic [15:0] instr [2];
   logic [7:0]  cur_data [2];

   // spec-level expectations
   function automatic int exp_busy(input int g);
      return (g == 0) ? (49 * 4 + 4) : (49 * 2 + 1);
   endfunction

   task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL u%0d %s actual=0x%0h required=0x%0h", g, nm, act, exp);
   endtask

   // Device model + scoreboard monitor, sampled away from the active edge.
   always @(negedge clock) begin
      exp_t e;
      cyc++;
      for (int g = 0; g < 2; g++) begin
         if (!rst_r[g]) begin
            if (!rst_done[g]) begin
               chk(g, "rst_cs_n",  32'(cs_w[g]),   32'd1);
               chk(g, "rst_sclk",  32'(sclk_w[g]), 32'd0);
               chk(g, "rst_sdio",  32'(sdio_w[g]), 32'd0);
               chk(g, "rst_busy",  32'(busy_w[g]), 32'd0);
               chk(g, "rst_valid", 32'(vld_w[g]),  32'd0);
               chk(g, "rst_data",  32'(rdd_w[g]),  32'd0);
               rst_done[g] = 1'b1;
            end
            prev_cs[g] = 1'b1; prev_sclk[g] = 1'b0; sdo_r[g] = 1'b0;
            busy_len[g] = 0; have_last[g] = 1'b0; high_run[g] = 0;
         end else begin
            rst_done[g] = 1'b0;
            if (!chk_b2b[g]) have_last[g] = 1'b0;
            // new transaction: device picks up the byte it will return
            if (prev_cs[g] && !cs_w[g]) begin
               rises[g] = 0; instr[g] = '0;
               if (g == 0) begin
                  chk(g, "cs_fall_requested", 32'(dev_q0.size() > 0), 32'd1);
                  cur_data[g] = (dev_q0.size() > 0) ? dev_q0.pop_front() : 8'h00;
               end else begin
                  chk(g, "cs_fall_requested", 32'(dev_q1.size() > 0), 32'd1);
                  cur_data[g] = (dev_q1.size() > 0) ? dev_q1.pop_front() : 8'h00;
               end
               if (chk_b2b[g] && have_last[g]) begin
                  chk(g, "b2b_period", 32'(cyc - last_fall[g]), 32'(exp_busy(g) + 1));
                  chk(g, "cs_high_gap", 32'(high_run[g]), (g == 0) ? 32'd5 : 32'd2);
               end
               last_fall[g] = cyc; have_last[g] = chk_b2b[g]; high_run[g] = 0;
            end
            if (cs_w[g]) high_run[g]++;
            // device samples SDIO on SCLK rise, launches SDO on SCLK fall
            if (!prev_sclk[g] && sclk_w[g]) begin
               if (rises[g] < 16) instr[g] = {instr[g][14:0], sdio_w[g]};
               rises[g]++;
            end
            if (prev_sclk[g] && !sclk_w[g] && rises[g] >= 16 && rises[g] < 24)
               sdo_r[g] = cur_data[g][23 - rises[g]];
            if (cs_w[g] && sclk_w[g]) viol[g]++;
            // busy window length
            if (busy_w[g]) busy_len[g]++;
            else if (busy_len[g] != 0) begin
               chk(g, "busy_len", 32'(busy_len[g]), 32'(exp_busy(g)));
               busy_len[g] = 0;
            end
            // read completion
            if (vld_w[g]) begin
               if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0))
                  chk(g, "rd_valid_unexpected", 32'(vld_w[g]), 32'd0);
               else begin
                  e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  chk(g, "rd_data",   32'(rdd_w[g]), 32'(e.data));
                  chk(g, "instr",     32'(instr[g]), 32'(16'h8000 | 16'(e.addr)));
                  chk(g, "sclk_rises", 32'(rises[g]), 32'd24);
                  chk(g, "cs_at_valid", 32'(cs_w[g]), 32'd1);
               end
            end
            prev_cs[g] = cs_w[g]; prev_sclk[g] = sclk_w[g];
         end
      end
      if (fin_req && !fin_done) begin
         chk(0, "pending_exp", 32'(exp_q0.size()), 32'd0);
         chk(1, "pending_exp", 32'(exp_q1.size()), 32'd0);
         chk(0, "sclk_while_cs_high", 32'(viol[0]), 32'd0);
         chk(1, "sclk_while_cs_high", 32'(viol[1]), 32'd0);
         fin_done = 1'b1;
      end
   end

   task automatic push(input int g, input logic [12:0] a, input logic [7:0] d, input bit expect_done);
      exp_t e;
      e.addr = a; e.data = d;
      if (g == 0) begin dev_q0.push_back(d); if (expect_done) exp_q0.push_back(e); end
      else        begin dev_q1.push_back(d); if (expect_done) exp_q1.push_back(e); end
   endtask

   task automatic pulse(input int g, input logic [12:0] a);
      @(negedge clock); addr_r[g] = a; start_r[g] = 1'b1;
      @(negedge clock); start_r[g] = 1'b0; addr_r[g] = 13'($urandom);
   endtask

   task automatic wait_idle(input int g);
      int n = 0;
      while (busy_w[g] && n < 2000) begin @(negedge clock); n++; end
      if (busy_w[g]) begin nto++; $display("FAIL u%0d idle_timeout busy=%0d", g, busy_w[g]); end
      @(negedge clock);
   endtask

   task automatic rd(input int g, input logic [12:0] a, input logic [7:0] d);
      push(g, a, d, 1'b1);
      pulse(g, a);
      wait_idle(g);
   endtask

   initial begin
      logic [12:0] a;
      logic [7:0]  d;
      int n;
      addr_r[0] = '0; addr_r[1] = '0;
      repeat (3) @(negedge clock);
      rst_r = 2'b11;
      repeat (2) @(negedge clock);

      // directed reads on the default instance
      rd(0, 13'h000, 8'h18);
      rd(0, 13'h01F, 8'hA5);

      // start re-pulsed during INSTR and HOLD must be ignored
      a = 13'($urandom); d = 8'($urandom);
      push(0, a, d, 1'b1);
      pulse(0, a);
      repeat (40) @(negedge clock);
      pulse(0, ~a);
      n = 0;
      while (!cs_w[0] && n < 1000) begin @(negedge clock); n++; end
      if (!cs_w[0]) begin nto++; $display("FAIL u0 hold_wait_timeout cs_n=%0d", cs_w[0]); end
      start_r[0] = 1'b1; addr_r[0] = 13'h0AA;
      @(negedge clock); start_r[0] = 1'b0;
      wait_idle(0);

      // start held for 500 cycles: three transactions, 201 cycles apart
      a = 13'($urandom);
      push(0, a, 8'h3C, 1'b1); push(0, a, 8'hC3, 1'b1); push(0, a, 8'h69, 1'b1);
      chk_b2b[0] = 1'b1;
      addr_r[0] = a; start_r[0] = 1'b1;
      repeat (500) @(negedge clock);
      start_r[0] = 1'b0;
      wait_idle(0);
      chk_b2b[0] = 1'b0;

      // reset at cycle 60 of a transaction, then a clean read of 0x1FFF
      push(0, 13'h123, 8'hFF, 1'b0);
      pulse(0, 13'h123);
      repeat (59) @(posedge clock);
      #2 rst_r[0] = 1'b0;
      repeat (3) @(negedge clock);
      rst_r[0] = 1'b1;
      repeat (2) @(negedge clock);
      rd(0, 13'h1FFF, 8'($urandom));

      // fast instance: bit-order check
      rd(1, 13'($urandom), 8'h01);
      rd(1, 13'($urandom), 8'h80);

      // randomized reads on both instances
      for (int i = 0; i < 4; i++) begin
         rd(0, 13'($urandom), 8'($urandom));
         rd(1, 13'($urandom), 8'($urandom));
      end

      repeat (5) @(negedge clock);
      fin_req = 1'b1;
      n = 0;
      while (!fin_done && n < 10) begin @(negedge clock); n++; end
      if (!fin_done) begin nto++; $display("FAIL final_check_timeout done=%0d", fin_done); end
      $display("%0d/%0d checks passed", npass, nchk + nto);
      $finish;
   end

endmodule

// File: doc/ad9516_spi_reader.md
Name: ad9516_spi_reader

Overview:
- SPI read-back engine for the AD9516 clock generator. It is the read-direction counterpart of the configuration write path.
- It issues one single-byte read instruction per request and shifts out R/W=1, W1:W0=00 and the 13-bit address.
- It then captures the 8-bit register value returned on SDO.
- Firmware and the config sequencer use it to verify programmed registers and to poll status (PLL lock, readback 0x1F).

Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period. Legal range 2..255.
- HOLD_CYC, 4: system clocks that CS stays high after a transaction before a new start is accepted. Legal range 1..255.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- reg_addr  in  13  AD9516 register address; captured when start is accepted
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- rd_data  out  8  last captured register value; held until the next rd_valid
- rd_valid  out  1  one-cycle pulse when rd_data is updated
- spi_cs_n  out  1  chip select, active low
- spi_sclk  out  1  serial clock, idle low
- spi_sdio  out  1  instruction data to the device, MSB first
- spi_sdo  in  1  read data from the device

Behaviour:
- Reset values (asynchronous on reset_n low, immediate):
  - state=IDLE, spi_cs_n=1, spi_sclk=0, spi_sdio=0, busy=0, rd_valid=0, rd_data=0x00.
  - All counters clear.
- Reset mid-transaction: CS deasserts in the same cycle reset_n falls. No rd_valid is produced.
- Instruction word: {1'b1, 2'b00, reg_addr[12:0]}, 16 bits, shifted MSB first.
- States:
  - IDLE: start=1 latches reg_addr, loads the shift register, sets spi_cs_n=0 and busy=1 on the next edge, and goes to SETUP. start in any other state is ignored.
  - SETUP: CLK_DIV cycles with CS low, SCLK low and spi_sdio=instruction bit 15. Then go to INSTR.
  - INSTR: 16 SCLK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
    - The device samples spi_sdio on the SCLK rising edge.
    - spi_sdio changes only on the system cycle that drives SCLK falling, presenting the next bit.
    - After the 16th high phase, drive SCLK low, set spi_sdio=0 and go to DATA.
  - DATA: 8 SCLK periods with the same timing.
    - spi_sdo is sampled on the system cycle that drives SCLK rising, i.e. the value present during the preceding low phase.
    - The sample shifts into rd_shift MSB first.
    - After the 8th high phase, SCLK goes low and spi_cs_n=1.
    - On the same cycle, rd_data<=rd_shift and rd_valid=1 for exactly one cycle.
    - Go to HOLD.
  - HOLD: HOLD_CYC cycles with CS high and busy=1. Then go to IDLE with busy=0.
- Total busy length: CLK_DIV + 48*CLK_DIV + HOLD_CYC cycles. With defaults this is 4+192+4 = 200.
- SCLK rising-edge count per transaction is exactly 24. SCLK never toggles while spi_cs_n=1.
- Back-to-back: start held high continuously gives a new transaction on the first IDLE cycle after HOLD. CS is therefore high for at least HOLD_CYC+1 cycles between transactions.
- Address wrap: reg_addr is taken verbatim. 0x1FFF is a legal value and is shifted as-is.
- spi_sdo is used directly; no synchroniser, since device data is launched by our own SCLK.

Test Plan:
- Reset, then start with reg_addr=0x000 and an SDO model returning 0x18 (serial-control register default) -> SDIO shows 0x8000. 24 SCLK rises. rd_data=0x18 with a single rd_valid pulse. Busy is high for 200 cycles.
- reg_addr=0x1F, SDO model returns 0xA5 -> instruction 0x801F decoded by the bench monitor. rd_data=0xA5. CS high in the same cycle as rd_valid.
- start re-pulsed during INSTR and during HOLD -> ignored. Exactly one transaction and one rd_valid.
- start held high for 500 cycles with defaults -> transactions begin 201 cycles apart. Minimum CS-high gap is 5 cycles. No SCLK edge while CS is high.
- reset_n asserted at cycle 60 of a transaction -> CS, SCLK and busy go to idle values immediately. No rd_valid. rd_data is 0x00. A subsequent read of 0x1FFF completes normally with instruction 0x9FFF.
- CLK_DIV=2, HOLD_CYC=1, SDO returns 0x01 then 0x80 on consecutive reads -> busy is 99 cycles each. rd_data is 0x01, then 0x80 (bit-order check).
